apb_req_arbiter: RTL and testbench
==================================

Name: apb_req_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one APB master's internal transfer port between NUM_REQ requesters (e.g. CPU core, DMA engine).
- Sits between the requesters and the master's transfer/ready/addr/wdata/write/rdata interface.
- Latches the winning request and issues exactly one transfer pulse.
- Tracks the master's IDLE->SETUP->ACCESS timing, returns read data and a completion pulse to the winner.

Parameters:
- NUM_REQ, 2, number of requesters (legal 2..4).
- DATA_W, 32, address/data width (fixed 32 for the APB master).

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request; held with payload until its req_ack.
- req_addr  in  NUM_REQ*DATA_W  packed addresses, requester i at [i*32+:32].
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- req_write  in  NUM_REQ  1=write, 0=read.
- req_lock  in  NUM_REQ  keep-grant request; used only with APB_ARB_LOCK_EN.
- req_ack  out  NUM_REQ  one-hot, 1-cycle completion pulse.
- resp_rdata  out  DATA_W  read data of the last completed transfer; valid in the req_ack cycle, held until the next completion.
- grant_id  out  2  index of the current or last granted requester.
- busy  out  1  high from ISSUE through ACCESS.
- m_transfer  out  1  to master transfer.
- m_addr  out  DATA_W  to master addr.
- m_wdata  out  DATA_W  to master wdata.
- m_write  out  1  to master write.
- m_ready  in  1  from master ready (slave PREADY mux); not state-gated, so it is meaningful only in ACCESS.
- m_rdata  in  DATA_W  from master rdata.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Last-grant pointer = NUM_REQ-1, so requester 0 has first priority.
  - PRESET is shared with the master, so both restart in IDLE. Reset mid-transfer discards the transfer; no req_ack is issued.
- States: IDLE, ISSUE, SETUP, ACCESS.
- IDLE:
  - Eligible set = req_valid & ~req_ack. This masks the requester being acked this cycle, whose valid is still high.
  - If the set is non-empty: pick the first set bit searching upward from last_grant+1, wrapping modulo NUM_REQ.
  - Register grant_id and the winner's addr/wdata/write into m_addr/m_wdata/m_write. Go to ISSUE.
- ISSUE:
  - m_transfer=1 for exactly this cycle; busy=1. The master is in IDLE and samples the payload.
  - Go to SETUP.
- SETUP:
  - m_ready is ignored (the master is in SETUP). Go to ACCESS.
- ACCESS:
  - Wait while m_ready=0; no timeout.
  - On m_ready=1: register resp_rdata<=m_rdata (written for writes too, value don't-care), set req_ack[grant_id] for the next cycle, update last_grant<=grant_id, go to IDLE.
  - The master also enters IDLE on that edge.
- Latency: req_valid seen in IDLE at cycle t gives m_transfer at t+1 and, with zero-wait slaves, req_ack at t+4. Back-to-back throughput is one transfer per 4 cycles.
- m_addr/m_wdata/m_write stay stable from ISSUE until the next grant.
- Payload changes on a requester's inputs after grant have no effect.
- Requests arriving during a transfer wait. A requester dropping req_valid before grant is simply not selected.
- Dropping req_valid after grant is illegal; the transfer still completes and req_ack still pulses.

Optional Feature:
- Macro APB_ARB_LOCK_EN.
- Defined: if the winner had req_lock=1 when it was acked, the next IDLE arbitration grants the same requester first if its req_valid=1 (the ack mask is waived for it). Otherwise normal round-robin applies. last_grant is unchanged while locked.
- Undefined: req_lock is ignored; pure round-robin.

Decomposition:
- Package apb_arb_pkg: state enum arb_state_e {IDLE, ISSUE, SETUP, ACCESS}; constants DATA_W=32 and MAX_REQ=4.
- Sub-module apb_rr_picker: combinational round-robin pick (inputs eligible mask and last_grant; outputs found and index), reused by other shared-bus arbiters.

Test Plan:
- Single read: req_valid[0], addr 0x1000_0004, slave PRDATA 0xDEAD_BEEF, PREADY=1.
  - Expect m_transfer at t+1 only; req_ack=2'b01 at t+4; resp_rdata=0xDEAD_BEEF.
- Single write with wait states: req 1 writes 0x1234_5678 to 0x1000_1000, slave PREADY low 3 ACCESS cycles.
  - Expect m_write=1 and m_wdata stable throughout; req_ack=2'b10 at t+7.
- Round-robin: both requesters continuously valid, 4 transfers.
  - Expect grant order 0,1,0,1; no requester acked twice in a row.
- Stale-valid mask: requester 0 alone, keeps valid 1 cycle after ack then drops it.
  - Expect exactly one transfer, no duplicate m_transfer.
- Reset mid-ACCESS: assert PRESET while m_ready=0.
  - Expect all outputs 0, state IDLE, no req_ack. After release, requester 0 wins first.
- APB_ARB_LOCK_EN: requester 1 with req_lock=1, both valid, 3 transfers.
  - Expect grants 0,1,1 (lock holds after first grant to 1); with the macro undefined, 0,1,0.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB requester arbiter and its picker.
package apb_arb_pkg;

  localparam int DATA_W  = 32;
  localparam int MAX_REQ = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    SETUP,
    ACCESS
  } arb_state_e;

endpackage

// File: rtl/apb_req_arbiter_if.sv
// Requester and APB-master transfer signals of the arbiter.
// The slave modport is the arbiter side; the master modport is the requesters plus master.
interface apb_req_arbiter_if #(
  parameter int NUM_REQ = 2
);
  import apb_arb_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ-1:0]        req_ack;
  logic [DATA_W-1:0]         resp_rdata;
  logic [1:0]                grant_id;
  logic                      busy;

  logic                      m_transfer;
  logic [DATA_W-1:0]         m_addr;
  logic [DATA_W-1:0]         m_wdata;
  logic                      m_write;
  logic                      m_ready;
  logic [DATA_W-1:0]         m_rdata;

  modport slave (
    input  req_valid, req_addr, req_wdata, req_write, req_lock,
    input  m_ready, m_rdata,
    output req_ack, resp_rdata, grant_id, busy,
    output m_transfer, m_addr, m_wdata, m_write
  );

  modport master (
    output req_valid, req_addr, req_wdata, req_write, req_lock,
    output m_ready, m_rdata,
    input  req_ack, resp_rdata, grant_id, busy,
    input  m_transfer, m_addr, m_wdata, m_write
  );

endinterface

// File: rtl/apb_rr_picker.sv
// Combinational round-robin pick: first eligible index above last_grant, wrapping.
// Shared by the bus arbiters; supports up to MAX_REQ requesters.
module apb_rr_picker
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [1:0]         last_grant,
  output logic               found,
  output logic [1:0]         index
);

  logic [MAX_REQ-1:0] elig_w;

  always_comb begin
    elig_w = '0;
    elig_w[NUM_REQ-1:0] = eligible;
  end

  // last_grant < NUM_REQ, so one conditional subtract is enough for the wrap
  always_comb begin
    logic [2:0] cand;
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant} + 3'(k);
      if (cand >= 3'(NUM_REQ))
        cand = cand - 3'(NUM_REQ);
      if (!found && elig_w[cand[1:0]]) begin
        found = 1'b1;
        index = cand[1:0];
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master transfer port between NUM_REQ requesters.
// Optional keep-grant support with APB_ARB_LOCK_EN defined.
//
// state  | meaning
// IDLE   | arbitrate; latch winner payload on a grant
// ISSUE  | m_transfer pulse, master samples payload
// SETUP  | master in SETUP, m_ready ignored
// ACCESS | wait for m_ready, then ack the winner
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic PCLK,
  input  logic PRESET,
  apb_req_arbiter_if.slave bus
);

  arb_state_e state_q, state_d;

  logic [MAX_REQ-1:0] valid_w;
  logic [MAX_REQ-1:0] write_w;
  logic [MAX_REQ-1:0] lock_w;
  logic [DATA_W-1:0]  addr_arr  [MAX_REQ];
  logic [DATA_W-1:0]  wdata_arr [MAX_REQ];

  logic [NUM_REQ-1:0] eligible;
  logic               pick_found;
  logic [1:0]         pick_idx;
  logic               grant_go;
  logic               done;
  logic [1:0]         win_idx;

  logic [1:0]         grant_id_q;
  logic [1:0]         last_grant_q;
  logic [DATA_W-1:0]  m_addr_q;
  logic [DATA_W-1:0]  m_wdata_q;
  logic               m_write_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [NUM_REQ-1:0] ack_q;
  logic [NUM_REQ-1:0] ack_onehot;

  // pad requester inputs to MAX_REQ so a 2-bit index always selects cleanly
  for (genvar g = 0; g < MAX_REQ; g++) begin : g_pad
    if (g < NUM_REQ) begin : g_real
      assign valid_w[g]   = bus.req_valid[g];
      assign write_w[g]   = bus.req_write[g];
      assign lock_w[g]    = bus.req_lock[g];
      assign addr_arr[g]  = bus.req_addr[g*DATA_W +: DATA_W];
      assign wdata_arr[g] = bus.req_wdata[g*DATA_W +: DATA_W];
    end else begin : g_zero
      assign valid_w[g]   = 1'b0;
      assign write_w[g]   = 1'b0;
      assign lock_w[g]    = 1'b0;
      assign addr_arr[g]  = '0;
      assign wdata_arr[g] = '0;
    end
  end

  // the requester being acked still shows valid this cycle
  assign eligible = bus.req_valid & ~ack_q;

  apb_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .eligible   (eligible),
    .last_grant (last_grant_q),
    .found      (pick_found),
    .index      (pick_idx)
  );

`ifdef APB_ARB_LOCK_EN
  logic lock_q;
  logic lock_hit;
  assign lock_hit = lock_q && valid_w[grant_id_q];
`endif

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      ack_onehot[i] = (grant_id_q == 2'(i));
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    grant_go = 1'b0;
    done     = 1'b0;
    win_idx  = pick_idx;
    case (state_q)
      IDLE: begin
`ifdef APB_ARB_LOCK_EN
        if (lock_hit) begin
          grant_go = 1'b1;
          win_idx  = grant_id_q;
        end else
`endif
        if (pick_found)
          grant_go = 1'b1;
        if (grant_go)
          state_d = ISSUE;
      end
      ISSUE:  state_d = SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (bus.m_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // a locked re-grant returns to the requester already in last_grant,
  // so updating last_grant on every completion leaves it unchanged while locked
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      grant_id_q   <= '0;
      last_grant_q <= 2'(NUM_REQ - 1);
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_write_q    <= 1'b0;
      rdata_q      <= '0;
      ack_q        <= '0;
`ifdef APB_ARB_LOCK_EN
      lock_q       <= 1'b0;
`endif
    end else begin
      ack_q <= '0;
      if (grant_go) begin
        grant_id_q <= win_idx;
        m_addr_q   <= addr_arr[win_idx];
        m_wdata_q  <= wdata_arr[win_idx];
        m_write_q  <= write_w[win_idx];
`ifdef APB_ARB_LOCK_EN
        lock_q     <= 1'b0;
`endif
      end
      if (done) begin
        rdata_q      <= bus.m_rdata;
        ack_q        <= ack_onehot;
        last_grant_q <= grant_id_q;
`ifdef APB_ARB_LOCK_EN
        lock_q       <= lock_w[grant_id_q];
`endif
      end
    end
  end

  assign bus.req_ack    = ack_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.grant_id   = grant_id_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.m_transfer = (state_q == ISSUE);
  assign bus.m_addr     = m_addr_q;
  assign bus.m_wdata    = m_wdata_q;
  assign bus.m_write    = m_write_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: requester queues, an APB slave emulation and a
// timestamp-based arbitration model checked every cycle, plus literal expectations.
module tb_apb_req_arbiter;

  localparam int NUM_REQ = 2;

  logic PCLK = 1'b0;
  logic PRESET;
  always #5 PCLK = ~PCLK;

  apb_req_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();
  apb_req_arbiter #(.NUM_REQ(NUM_REQ)) dut (.PCLK(PCLK), .PRESET(PRESET), .bus(bus));

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        write;
    logic        lock;
    logic [7:0]  waits;
  } txn_t;

  txn_t rq [NUM_REQ][$];

  int cyc;
  bit act;
  int tg, win, last;
  bit lock_hold;
  bit rst_req;
  logic [1:0]         m_gid;
  logic [31:0]        m_addr_e, m_wdata_e, m_rdata_e;
  logic               m_write_e;
  logic [NUM_REQ-1:0] m_ack_e, ack_prev;

  logic [NUM_REQ-1:0] e_ack;
  logic [31:0]        e_rdata, e_addr, e_wdata;
  logic [1:0]         e_gid;
  logic               e_busy, e_xfer, e_write;

  int n_tests, n_fail;
  int xfer_log[$];
  int ack_cyc[$];
  logic [NUM_REQ-1:0] ack_vec[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  always @(negedge PCLK) begin
    chk("req_ack",    32'(bus.req_ack),    32'(e_ack));
    chk("resp_rdata", bus.resp_rdata,      e_rdata);
    chk("grant_id",   32'(bus.grant_id),   32'(e_gid));
    chk("busy",       32'(bus.busy),       32'(e_busy));
    chk("m_transfer", 32'(bus.m_transfer), 32'(e_xfer));
    chk("m_addr",     bus.m_addr,          e_addr);
    chk("m_wdata",    bus.m_wdata,         e_wdata);
    chk("m_write",    32'(bus.m_write),    32'(e_write));
    if (bus.m_transfer) xfer_log.push_back(cyc);
    if (bus.req_ack != '0) begin
      ack_cyc.push_back(cyc);
      ack_vec.push_back(bus.req_ack);
    end
  end

  task automatic model_reset();
    act = 0; tg = 0; win = 0; last = NUM_REQ - 1; lock_hold = 0;
    m_gid = '0; m_addr_e = '0; m_wdata_e = '0; m_rdata_e = '0;
    m_write_e = 1'b0; m_ack_e = '0;
  endtask

  function automatic bit pending();
    pending = act;
    for (int i = 0; i < NUM_REQ; i++)
      if (rq[i].size() != 0) pending = 1;
  endfunction

  // one clock cycle: drive inputs, snapshot expectations, advance model
  task automatic step();
    logic [NUM_REQ-1:0] v, nack;
    logic [31:0] a, w;
    bit found;
    int pick, j;
    for (int i = 0; i < NUM_REQ; i++)
      if (ack_prev[i] && rq[i].size() != 0) void'(rq[i].pop_front());
    PRESET = rst_req;
    if (rst_req) model_reset();
    v = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rq[i].size() != 0) begin
        v[i] = 1'b1;
        a = rq[i][0].addr;
        w = rq[i][0].wdata;
        if (act && win == i) begin
          a = a ^ 32'hFFFF_0000;
          w = ~w;
        end
        bus.req_write[i] = rq[i][0].write;
        bus.req_lock[i]  = rq[i][0].lock;
      end else begin
        a = 32'hA5A5_0000 ^ 32'(cyc);
        w = 32'h5A5A_0000 ^ 32'(cyc);
        bus.req_write[i] = 1'b0;
        bus.req_lock[i]  = 1'b0;
      end
      bus.req_addr[i*32 +: 32]  = a;
      bus.req_wdata[i*32 +: 32] = w;
    end
    bus.req_valid = v;
    // slave: ready is raised in SETUP too, which the arbiter must ignore
    bus.m_ready = 1'b0;
    bus.m_rdata = 32'hBAD0_0000 ^ 32'(cyc);
    if (act && cyc == tg + 2) bus.m_ready = 1'b1;
    if (act && cyc >= tg + 3 && rq[win].size() != 0) begin
      bus.m_ready = (cyc - tg - 3 >= int'(rq[win][0].waits));
      bus.m_rdata = rq[win][0].rdata;
    end
    e_ack = m_ack_e; e_rdata = m_rdata_e; e_gid = m_gid;
    e_addr = m_addr_e; e_wdata = m_wdata_e; e_write = m_write_e;
    e_busy = act; e_xfer = act && (cyc == tg + 1);
    if (!rst_req) begin
      nack = '0;
      if (!act) begin
        found = 0; pick = 0;
`ifdef APB_ARB_LOCK_EN
        if (lock_hold && v[m_gid]) begin found = 1; pick = int'(m_gid); end
`endif
        for (int k = 1; k <= NUM_REQ; k++) begin
          j = (last + k) % NUM_REQ;
          if (!found && v[j] && !m_ack_e[j]) begin found = 1; pick = j; end
        end
        if (found) begin
          act = 1; tg = cyc; win = pick; m_gid = 2'(pick); lock_hold = 0;
          m_addr_e  = bus.req_addr[pick*32 +: 32];
          m_wdata_e = bus.req_wdata[pick*32 +: 32];
          m_write_e = bus.req_write[pick];
        end
      end else if (cyc >= tg + 3 && bus.m_ready) begin
        nack[win] = 1'b1;
        m_rdata_e = bus.m_rdata;
        last = win;
        lock_hold = bus.req_lock[win];
        act = 0;
      end
      m_ack_e = nack;
    end
    ack_prev = e_ack;
    @(posedge PCLK);
    #1;
    cyc++;
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      step();
      n++;
    end
    if (pending()) begin
      n_tests++; n_fail++;
      $display("FAIL timeout cyc=%0d got=busy exp=idle within %0d cycles", cyc, budget);
    end
  endtask

  task automatic clear_logs();
    xfer_log.delete(); ack_cyc.delete(); ack_vec.delete();
  endtask

  function automatic txn_t mk(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic write,
                              input logic lock, input int waits);
    mk = '{addr: addr, wdata: wdata, rdata: rdata, write: write, lock: lock, waits: 8'(waits)};
  endfunction

  int t0;

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; ack_prev = '0;
    rst_req = 1;
    step(); step(); step();
    rst_req = 0;
    step();

    // single read, zero wait
    clear_logs(); t0 = cyc;
    rq[0].push_back(mk(32'h1000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 0));
    run_until_idle(40);
    chk("s1_xfer_n", xfer_log.size(), 1);
    chk("s1_ack_n",  ack_cyc.size(), 1);
    if (xfer_log.size() > 0) chk("s1_xfer_lat", xfer_log[0] - t0, 1);
    if (ack_cyc.size() > 0) begin
      chk("s1_ack_lat", ack_cyc[0] - t0, 4);
      chk("s1_ack_vec", 32'(ack_vec[0]), 32'h1);
    end
    chk("s1_rdata", bus.resp_rdata, 32'hDEAD_BEEF);

    // single write from requester 1 with three wait states
    clear_logs(); t0 = cyc;
    rq[1].push_back(mk(32'h1000_1000, 32'h1234_5678, 32'h0, 1'b1, 1'b0, 3));
    run_until_idle(40);
    chk("s2_ack_n", ack_cyc.size(), 1);
    if (ack_cyc.size() > 0) begin
      chk("s2_ack_lat", ack_cyc[0] - t0, 7);
      chk("s2_ack_vec", 32'(ack_vec[0]), 32'h2);
    end
    chk("s2_m_write", 32'(bus.m_write), 32'h1);
    chk("s2_m_wdata", bus.m_wdata, 32'h1234_5678);

    // both requesters continuously valid
    clear_logs();
    rq[0].push_back(mk(32'h2000_0000, 32'h0, 32'h0A0A_0001, 1'b0, 1'b0, 0));
    rq[0].push_back(mk(32'h2000_0010, 32'h0, 32'h0A0A_0002, 1'b0, 1'b0, 1));
    rq[1].push_back(mk(32'h3000_0000, 32'hC0DE_0001, 32'h0, 1'b1, 1'b0, 0));
    rq[1].push_back(mk(32'h3000_0020, 32'hC0DE_0002, 32'h0, 1'b1, 1'b0, 2));
    run_until_idle(80);
    chk("s3_ack_n", ack_vec.size(), 4);
    if (ack_vec.size() == 4) begin
      chk("s3_g0", 32'(ack_vec[0]), 32'h1);
      chk("s3_g1", 32'(ack_vec[1]), 32'h2);
      chk("s3_g2", 32'(ack_vec[2]), 32'h1);
      chk("s3_g3", 32'(ack_vec[3]), 32'h2);
    end

    // stale valid in the ack cycle must not retrigger
    clear_logs();
    rq[0].push_back(mk(32'h4000_0000, 32'h0, 32'h5555_AAAA, 1'b0, 1'b0, 0));
    run_until_idle(40);
    step(); step(); step();
    chk("s4_xfer_n", xfer_log.size(), 1);
    chk("s4_ack_n",  ack_cyc.size(), 1);

    // reset while ACCESS is waiting on m_ready
    clear_logs();
    rq[0].push_back(mk(32'h5000_0000, 32'h0, 32'h1111_2222, 1'b0, 1'b0, 50));
    for (int i = 0; i < 5; i++) step();
    rst_req = 1;
    rq[0].delete(); rq[1].delete();
    step(); step();
    rst_req = 0;
    step();
    chk("s5_ack_n", ack_cyc.size(), 0);
    chk("s5_busy",  32'(bus.busy), 32'h0);

    // post-reset priority and keep-grant
    clear_logs();
    rq[0].push_back(mk(32'h6000_0000, 32'h0, 32'h6666_0000, 1'b0, 1'b0, 0));
    rq[0].push_back(mk(32'h6000_0004, 32'h0, 32'h6666_0004, 1'b0, 1'b0, 0));
    rq[1].push_back(mk(32'h7000_0000, 32'h7777_0000, 32'h0, 1'b1, 1'b1, 0));
    rq[1].push_back(mk(32'h7000_0004, 32'h7777_0004, 32'h0, 1'b1, 1'b0, 1));
    run_until_idle(80);
    chk("s6_ack_n", ack_vec.size(), 4);
    if (ack_vec.size() >= 3) begin
      chk("s6_g0", 32'(ack_vec[0]), 32'h1);
      chk("s6_g1", 32'(ack_vec[1]), 32'h2);
`ifdef APB_ARB_LOCK_EN
      chk("s6_g2", 32'(ack_vec[2]), 32'h2);
`else
      chk("s6_g2", 32'(ack_vec[2]), 32'h1);
`endif
    end

    step(); step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
